// File: rtl/loader_defs.sv
// Shared definitions for the UART program loader: FSM encodings, default sync
// byte and the framing field sizes of the load protocol.
package loader_defs;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_BYTES     = 2;
    localparam int         WORD_BYTES    = 4;
    localparam int         LEN_W         = LEN_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, falling-edge start detection with
// mid-bit glitch recheck, LSB-first data sampling and stop-bit framing check.
module uart_rx_byte
    import loader_defs::*;
#(
    parameter int CLKS_PER_BIT = 174
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        rx_state, rx_state_nx;
    logic             rx_p0, rx_p1, rx_p2;
    logic [CNT_W-1:0] bit_tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             half_hit, full_hit, fall;

    // rx_p2 is the previous synchronized level, used only for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign fall     = rx_p2 && !rx_p1;
    assign half_hit = (bit_tmr == HALF_M1);
    assign full_hit = (bit_tmr == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_state_nx = RX_START;
            RX_START: if (half_hit) rx_state_nx = rx_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP:  if (full_hit) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rx_state == RX_STOP && full_hit) begin
            byte_valid = rx_p1;
            frame_err  = !rx_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (rx_state_nx != rx_state || full_hit || rx_state == RX_IDLE)
                bit_tmr <= '0;
            else
                bit_tmr <= bit_tmr + CNT_W'(1);
            if (rx_state == RX_START)
                bit_idx <= '0;
            else if (rx_state == RX_DATA && full_hit) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {rx_p1, shreg[7:1]};
            end
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: frames SYNC, 16-bit word count and big-endian words
// into instruction-memory writes. Define UART_PROG_LOADER_CHECKSUM_EN for a trailing checksum byte.
module uart_prog_loader
    import loader_defs::*;
#(
    parameter int         CLKS_PER_BIT = 174,
    parameter int         ADDR_W       = 14,
    parameter int         TIMEOUT_CLKS = 2000000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t             state, state_nx;
    logic               byte_valid, frame_err;
    logic [7:0]         byte_data;
    logic [7:0]         len_hi;
    logic [LEN_W-1:0]   len, len_n, word_cnt;
    logic [1:0]         byte_cnt;
    logic [23:0]        word_sr;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               in_load, tmo_hit, too_long, last_byte, last_word, is_sync, load_fault;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign in_load    = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                        (state == ST_DATA)   || (state == ST_CKSUM);
    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CLKS));
    assign load_fault = frame_err || tmo_hit;
    assign len_n      = {len_hi, byte_data};
    assign too_long   = {{(32 - LEN_W){1'b0}}, len_n} > MAX_WORDS;
    assign last_byte  = (byte_cnt == 2'(WORD_BYTES - 1));
    assign last_word  = ((word_cnt + LEN_W'(1)) == len);
    assign is_sync    = (byte_data == SYNC_BYTE);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0] cksum;

    always_ff @(posedge clk) begin
        if (rst)
            cksum <= '0;
        else if (byte_valid && (state == ST_IDLE || state == ST_ERR) && is_sync)
            cksum <= '0;
        else if (byte_valid && state == ST_DATA)
            cksum <= cksum + byte_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // A byte in the same cycle as a fault takes priority
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_ERR:
                if (byte_valid && is_sync) state_nx = ST_LEN_HI;
            ST_LEN_HI:
                if (byte_valid)      state_nx = ST_LEN_LO;
                else if (load_fault) state_nx = ST_ERR;
            ST_LEN_LO:
                if (byte_valid) begin
                    if (len_n == '0)   state_nx = ST_AFTER_DATA;
                    else if (too_long) state_nx = ST_ERR;
                    else               state_nx = ST_DATA;
                end else if (load_fault) state_nx = ST_ERR;
            ST_DATA:
                if (byte_valid) begin
                    if (last_byte && last_word) state_nx = ST_AFTER_DATA;
                end else if (load_fault) state_nx = ST_ERR;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            ST_CKSUM:
                if (byte_valid)      state_nx = (byte_data == cksum) ? ST_DONE : ST_ERR;
                else if (load_fault) state_nx = ST_ERR;
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_rst_hold = 1'b0;
        load_busy    = 1'b0;
        load_done    = 1'b0;
        load_err     = 1'b0;
        case (state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CKSUM: begin
                cpu_rst_hold = 1'b1;
                load_busy    = 1'b1;
            end
            ST_DONE: load_done = 1'b1;
            ST_ERR: begin
                cpu_rst_hold = 1'b1;
                load_err     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            tmo_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (!in_load || byte_valid) tmo_cnt <= '0;
            else                        tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (byte_valid) begin
                case (state)
                    ST_LEN_HI: len_hi <= byte_data;
                    ST_LEN_LO: begin
                        len      <= len_n;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                    ST_DATA: begin
                        word_sr  <= {word_sr[15:0], byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {word_sr, byte_data};
                            word_cnt   <= word_cnt + LEN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader for the minisys 32 CPU.
- Receives an 8N1 UART stream, assembles 32-bit words and writes them into instruction memory through that memory's write port. It writes the same memory that the IFetch stage reads.
- Holds the CPU in reset while a load is in progress and releases it when the load completes.
- Sits beside cpu_top. Its cpu_rst_hold output is ORed with the board reset before the CPU sees it.

Parameters:
- CLKS_PER_BIT, 174: clock cycles per UART bit (20 MHz / 115200). Must be at least 4.
- ADDR_W, 14: instruction-memory word-address width (16K words).
- TIMEOUT_CLKS, 2000000: idle cycles tolerated between bytes once a load has started.
- SYNC_BYTE, 8'hA5: byte that starts a load.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- uart_rx, in, 1: serial input. Asynchronous; idles high.
- imem_we, out, 1: instruction-memory write strobe. One-cycle pulse per word.
- imem_addr, out, ADDR_W: word address of the write.
- imem_wdata, out, 32: word being written.
- cpu_rst_hold, out, 1: holds the CPU in reset while high.
- load_busy, out, 1: high from SYNC_BYTE acceptance until the DONE or ERR state.
- load_done, out, 1: one-cycle pulse when a load completes successfully.
- load_err, out, 1: sticky error flag.

Behaviour:
- Reset: all outputs are 0.
  - imem_addr = 0 and imem_wdata = 0.
  - FSM goes to IDLE, all counters clear, the synchronizer flops are set to 1.
  - cpu_rst_hold = 0, so the CPU runs the preloaded memory image.
- Reset mid-load: same as above. Words already written stay in memory.
- RX path:
  - uart_rx passes through a 2-FF synchronizer.
  - A falling edge starts a bit timer. The line is re-checked at CLKS_PER_BIT/2; if it is high again, the edge is treated as a glitch and the receiver returns to idle.
  - The 8 data bits are sampled every CLKS_PER_BIT cycles at mid-bit, LSB first. The stop bit is sampled the same way.
  - Stop bit = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop bit = 0: frame_err pulses for 1 cycle and no byte is delivered.
- Loader FSM: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE sets cpu_rst_hold=1, sets load_busy=1, clears load_err, and goes to LEN_HI.
  - LEN_HI / LEN_LO: build the 16-bit word count N, high byte first.
    - N = 0 goes to DONE.
    - N > 2^ADDR_W goes to ERR.
    - Otherwise go to DATA with word index = 0 and byte count = 0.
  - DATA: words arrive MSB byte first. Each byte shifts into a 32-bit register.
    - On the 4th byte, imem_we=1 in the next cycle only, with imem_addr = word index and imem_wdata = the assembled word.
    - Word index then increments. After the Nth write the FSM goes to DONE.
  - DONE: load_done=1 for 1 cycle. cpu_rst_hold and load_busy drop in that same cycle. Next state is IDLE.
  - ERR: load_err=1 and stays set. cpu_rst_hold stays 1, so the CPU remains in reset with a partial image. load_busy=0. The only exits are a new SYNC_BYTE (which restarts the load) or rst.
- Timeout and frame errors:
  - In LEN_HI, LEN_LO and DATA, a counter clears on every byte_valid. When it reaches TIMEOUT_CLKS the FSM goes to ERR.
  - frame_err in those states also goes to ERR.
- Simultaneous events: if byte_valid and timeout occur in the same cycle, the byte wins and the counter clears.
- Address wrap: cannot occur, because N is bounded by the length check.

Optional Feature:
- Macro: UART_PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An extra state CKSUM follows the last data word.
  - An 8-bit running sum (mod 256) of all data bytes is kept. It excludes the sync byte and the length bytes.
  - The next received byte must equal the sum: a match goes to DONE, a mismatch goes to ERR.
  - Timeout and frame errors apply in CKSUM as in the other load states.
  - With N=0 the expected checksum byte is 8'h00.
- Not defined: the FSM goes to DONE directly after the last write, and the checksum logic is not synthesized.

Decomposition:
- Package loader_defs: FSM state encoding and the default SYNC_BYTE. It also holds the protocol field constants, LEN_BYTES=2 and WORD_BYTES=4.
- Sub-module uart_rx_byte:
  - Contains the synchronizer, bit timer and shift register.
  - Ports: clk, rst, rx, byte_valid, byte_data[7:0], frame_err. Parameter: CLKS_PER_BIT.
- uart_prog_loader: contains the framing FSM, word assembly, timeout counter and checksum.

Test Plan (sim with CLKS_PER_BIT=8, TIMEOUT_CLKS=400, ADDR_W=4):
- Send A5 00 02 12 34 56 78 DE AD BE EF -> imem_we pulses twice: (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF). load_done pulses once and cpu_rst_hold returns to 0.
- Send 33 FF then A5 00 00 -> the leading bytes are ignored, no writes occur, load_done pulses, load_err=0.
- Send A5 00 11 (N=17 > 16) -> ERR: load_err=1, cpu_rst_hold=1, imem_we never asserts.
- Send A5 00 01 AA BB, then go silent -> ERR after 400 idle cycles. Then send A5 00 01 01 02 03 04 -> load_err clears and (addr 0, 0x01020304) is written.
- Apply a 2-cycle low glitch on uart_rx, then a frame with stop bit = 0 during DATA -> the glitch produces no byte; the bad frame gives ERR. Asserting rst mid-DATA returns all outputs to 0.
- With CHECKSUM_EN: send A5 00 01 01 02 03 04 0A -> DONE. The same frame with checksum 0B -> ERR with load_err=1.
